// File: rtl/led_matrix_scan_ctrl_if.sv
// Host/display bus of the LED matrix scan controller: frame-store writes,
// bank swap handshake, and the decoder/column drive.
interface led_matrix_scan_ctrl_if;
  logic       scan_en;
  logic       wr_en;
  logic [2:0] wr_row;
  logic [7:0] wr_data;
  logic       wr_ready;
  logic       swap_req;
  logic       swap_ack;
  logic       frame_start;
  logic [2:0] row_sel;
  logic       dec_en_b0;
  logic       dec_en_b1;
  logic       dec_en2;
  logic [7:0] col_data;

  modport master (
    output scan_en, wr_en, wr_row, wr_data, swap_req,
    input  wr_ready, swap_ack, frame_start, row_sel,
           dec_en_b0, dec_en_b1, dec_en2, col_data
  );

  modport slave (
    input  scan_en, wr_en, wr_row, wr_data, swap_req,
    output wr_ready, swap_ack, frame_start, row_sel,
           dec_en_b0, dec_en_b1, dec_en2, col_data
  );
endinterface

// File: rtl/led_matrix_scan_ctrl.sv
// Blanked row scan for an 8x8 LED matrix behind a 74HC138 row decoder, with a
// double-buffered frame store that swaps banks only on frame boundaries.
module led_matrix_scan_ctrl #(
  parameter int DWELL_CYCLES = 4,
  parameter int DWELL_W      = 8
) (
  input  logic                 clk,
  input  logic                 reset,
  led_matrix_scan_ctrl_if.slave bus
);

  // ST_IDLE is the parked blank (scan_en low, or just out of reset); it looks
  // exactly like BLANK on the pins but always leads into a fresh row-0 BLANK.
  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_BLANK = 2'd1,
    ST_DRIVE = 2'd2
  } state_e;

  localparam logic [DWELL_W-1:0] DWELL_LAST = DWELL_W'(DWELL_CYCLES - 1);

  state_e               state_q, state_d;
  logic [2:0]           row_q, row_d;
  logic [DWELL_W-1:0]   dwell_q, dwell_d;
  logic                 front_q, front_d;
  logic                 pending_q, pending_d;
  logic                 parked_q, parked_d;
  logic                 swap_d;
  logic                 fstart_d;
  logic [7:0]           col_d;
  logic                 wr_fire;
  logic [7:0]           bank_q [0:1][0:7];

  logic [2:0]           row_sel_q;
  logic                 dec_en_b_q;
  logic                 dec_en2_q;
  logic [7:0]           col_q;
  logic                 wr_ready_q;
  logic                 swap_ack_q;
  logic                 frame_start_q;

  assign wr_fire = bus.wr_en && wr_ready_q;

  always_comb begin
    state_d   = state_q;
    row_d     = row_q;
    dwell_d   = dwell_q;
    front_d   = front_q;
    pending_d = pending_q;
    parked_d  = parked_q;
    swap_d    = 1'b0;
    fstart_d  = 1'b0;

    if (!bus.scan_en) begin
      state_d  = ST_IDLE;
      row_d    = 3'd0;
      dwell_d  = '0;
      parked_d = 1'b1;
    end else begin
      case (state_q)
        ST_IDLE: begin
          state_d  = ST_BLANK;
          row_d    = 3'd0;
          dwell_d  = '0;
          fstart_d = 1'b1;
        end
        ST_BLANK: begin
          state_d  = ST_DRIVE;
          dwell_d  = '0;
          parked_d = 1'b0;
          // Restarting after a park: nothing is on screen, so swap right away.
          swap_d   = parked_q && pending_q;
        end
        ST_DRIVE: begin
          if (dwell_q == DWELL_LAST) begin
            state_d = ST_BLANK;
            row_d   = row_q + 3'd1;
            dwell_d = '0;
            if (row_q == 3'd7) begin
              fstart_d = 1'b1;
              swap_d   = pending_q;
            end
          end else begin
            dwell_d = dwell_q + DWELL_W'(1);
          end
        end
        default: state_d = ST_IDLE;
      endcase
    end

    // A request arriving in the swap cycle itself waits for the next boundary.
    if (swap_d) begin
      front_d   = ~front_q;
      pending_d = bus.swap_req;
    end else if (bus.swap_req) begin
      pending_d = 1'b1;
    end

    col_d = (state_d == ST_DRIVE) ? bank_q[front_d][row_d] : 8'h00;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= ST_IDLE;
      row_q         <= 3'd0;
      dwell_q       <= '0;
      front_q       <= 1'b0;
      pending_q     <= 1'b0;
      parked_q      <= 1'b1;
      row_sel_q     <= 3'd0;
      dec_en_b_q    <= 1'b1;
      dec_en2_q     <= 1'b0;
      col_q         <= 8'h00;
      wr_ready_q    <= 1'b1;
      swap_ack_q    <= 1'b0;
      frame_start_q <= 1'b0;
      for (int b = 0; b < 2; b++) begin
        for (int r = 0; r < 8; r++) begin
          bank_q[b][r] <= 8'h00;
        end
      end
    end else begin
      state_q       <= state_d;
      row_q         <= row_d;
      dwell_q       <= dwell_d;
      front_q       <= front_d;
      pending_q     <= pending_d;
      parked_q      <= parked_d;
      row_sel_q     <= row_d;
      dec_en_b_q    <= (state_d != ST_DRIVE);
      dec_en2_q     <= (state_d == ST_DRIVE);
      col_q         <= col_d;
      wr_ready_q    <= ~pending_d;
      swap_ack_q    <= swap_d;
      frame_start_q <= fstart_d;
      if (wr_fire) begin
        bank_q[~front_q][bus.wr_row] <= bus.wr_data;
      end
    end
  end

  assign bus.row_sel     = row_sel_q;
  assign bus.dec_en_b0   = dec_en_b_q;
  assign bus.dec_en_b1   = dec_en_b_q;
  assign bus.dec_en2     = dec_en2_q;
  assign bus.col_data    = col_q;
  assign bus.wr_ready    = wr_ready_q;
  assign bus.swap_ack    = swap_ack_q;
  assign bus.frame_start = frame_start_q;

endmodule

// File: tb/tb_led_matrix_scan_ctrl.sv
// Bench for led_matrix_scan_ctrl: frame-position reference model with two
// frame arrays that are exchanged on swap, plus directed and random scenarios.
module tb_led_matrix_scan_ctrl;
  localparam int D = 4;
  localparam int P = 8 * (D + 1);
  localparam logic [16:0] RESET_VEC = {3'd0, 1'b1, 1'b1, 1'b0, 8'h00, 1'b1, 1'b0, 1'b0};

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  led_matrix_scan_ctrl_if bus();

  led_matrix_scan_ctrl #(.DWELL_CYCLES(D), .DWELL_W(8)) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  int errors = 0;
  int checks = 0;

  bit         m_active, m_parked, m_pending, m_ack;
  int         m_pos;
  logic [7:0] m_front [8];
  logic [7:0] m_back  [8];

  // Model reacts to the inputs present at the upcoming edge.
  task automatic model_edge();
    logic [7:0] tmp [8];
    bit swap;
    if (reset) begin
      for (int i = 0; i < 8; i++) begin
        m_front[i] = 8'h00;
        m_back[i]  = 8'h00;
      end
      m_active = 0; m_parked = 1; m_pending = 0; m_ack = 0; m_pos = 0;
      return;
    end
    swap = 0;
    if (bus.wr_en && !m_pending) m_back[bus.wr_row] = bus.wr_data;
    if (!bus.scan_en) begin
      m_active = 0;
      m_parked = 1;
    end else if (!m_active) begin
      m_active = 1;
      m_pos = 0;
    end else begin
      m_pos++;
      if (m_pos % P == 0) swap = m_pending;
      if (m_pos == 1) begin
        if (m_parked) swap = m_pending;
        m_parked = 0;
      end
    end
    m_ack = swap;
    if (swap) begin
      tmp = m_front; m_front = m_back; m_back = tmp;
      m_pending = bus.swap_req;
    end else if (bus.swap_req) begin
      m_pending = 1;
    end
  endtask

  task automatic tick();
    model_edge();
    @(posedge clk);
    @(negedge clk);
  endtask

  function automatic logic [16:0] exp_vec();
    int k;
    logic [2:0] r;
    bit drv;
    k   = m_pos % P;
    r   = m_active ? 3'(k / (D + 1)) : 3'd0;
    drv = m_active && (k % (D + 1) != 0);
    return {r, !drv, !drv, drv, drv ? m_front[r] : 8'h00, !m_pending, m_ack, m_active && (k == 0)};
  endfunction

  function automatic logic [16:0] obs_vec();
    return {bus.row_sel, bus.dec_en_b0, bus.dec_en_b1, bus.dec_en2, bus.col_data,
            bus.wr_ready, bus.swap_ack, bus.frame_start};
  endfunction

  function automatic int m_row();
    return (m_pos % P) / (D + 1);
  endfunction

  function automatic bit m_drive();
    return m_active && ((m_pos % P) % (D + 1) != 0);
  endfunction

  task automatic test_reset();
    reset = 1'b1;
    bus.scan_en = 1'($urandom_range(0, 1));
    tick(); tick();
    checks++;
    if (obs_vec() !== RESET_VEC) begin
      errors++;
      $display("FAIL reset_values: got %h expected %h", obs_vec(), RESET_VEC);
    end
    reset = 1'b0;
  endtask

  task automatic test_scan();
    int last_fs = -1;
    bus.scan_en = 1'b1;
    for (int c = 0; c < 2 * P + 7; c++) begin
      tick();
      checks++;
      if (obs_vec() !== exp_vec()) begin
        errors++;
        $display("FAIL scan_vec cyc %0d: got %h expected %h", c, obs_vec(), exp_vec());
      end
      if (bus.frame_start === 1'b1) begin
        if (last_fs >= 0) begin
          checks++;
          if (c - last_fs !== P) begin
            errors++;
            $display("FAIL frame_period: got %0d expected %0d", c - last_fs, P);
          end
        end
        last_fs = c;
      end
    end
  endtask

  // Waits for swap_ack with full-vector checking; returns cycles waited.
  task automatic wait_ack(input string nm, input int limit, output int n);
    n = 0;
    while (bus.swap_ack !== 1'b1 && n < limit) begin
      tick();
      n++;
      checks++;
      if (obs_vec() !== exp_vec()) begin
        errors++;
        $display("FAIL %s_vec: got %h expected %h", nm, obs_vec(), exp_vec());
      end
    end
    checks++;
    if (bus.swap_ack !== 1'b1) begin
      errors++;
      $display("FAIL %s_timeout: got no swap_ack expected one within %0d cycles", nm, limit);
    end
  endtask

  // One frame after a boundary ack: column drive must match a frame with a single lit row.
  task automatic frame_check(input string nm, input int lit_row, input logic [7:0] lit_val);
    int k;
    logic [7:0] e;
    for (int j = 1; j <= P; j++) begin
      tick();
      k = j % P;
      e = ((k % (D + 1)) != 0 && (k / (D + 1)) == lit_row) ? lit_val : 8'h00;
      checks++;
      if (bus.col_data !== e) begin
        errors++;
        $display("FAIL %s_col k=%0d: got %h expected %h", nm, k, bus.col_data, e);
      end
    end
  endtask

  task automatic test_swap();
    int n;
    bus.wr_en = 1'b1; bus.wr_row = 3'd3; bus.wr_data = 8'hA5;
    tick();
    bus.wr_en = 1'b0; bus.swap_req = 1'b1;
    tick();
    bus.swap_req = 1'b0;
    checks++;
    if (bus.wr_ready !== 1'b0) begin
      errors++;
      $display("FAIL swap_wr_ready: got %b expected 0", bus.wr_ready);
    end
    wait_ack("swap", 2 * P, n);
    checks++;
    if ({bus.frame_start, bus.row_sel, bus.dec_en2, bus.wr_ready} !== {1'b1, 3'd0, 1'b0, 1'b1}) begin
      errors++;
      $display("FAIL swap_ack_at_blank0: got %b expected 100001",
               {bus.frame_start, bus.row_sel, bus.dec_en2, bus.wr_ready});
    end
    frame_check("swap_frame", 3, 8'hA5);
  endtask

  task automatic test_drop_write();
    int n;
    bus.swap_req = 1'b1;
    tick();
    bus.swap_req = 1'b0;
    bus.wr_en = 1'b1; bus.wr_row = 3'd2; bus.wr_data = 8'hFF;
    tick();
    bus.wr_en = 1'b0;
    wait_ack("drop", 2 * P, n);
    frame_check("drop_frame", 2, 8'h00);
    bus.swap_req = 1'b1;
    tick();
    bus.swap_req = 1'b0;
    wait_ack("drop_back", 2 * P, n);
    frame_check("drop_back_frame", 3, 8'hA5);
  endtask

  task automatic test_back_to_back();
    int n, k;
    logic [7:0] e;
    bus.wr_en = 1'b1; bus.wr_row = 3'd1; bus.wr_data = 8'h3C;
    tick();
    bus.wr_en = 1'b0; bus.swap_req = 1'b1;
    tick();
    bus.swap_req = 1'b0;
    n = 0;
    while (!(m_active && ((m_pos + 1) % P == 0)) && n < 2 * P) begin
      tick();
      n++;
    end
    bus.swap_req = 1'b1;
    tick();
    bus.swap_req = 1'b0;
    checks++;
    if (bus.swap_ack !== 1'b1) begin
      errors++;
      $display("FAIL b2b_first_ack: got %b expected 1", bus.swap_ack);
    end
    n = 0;
    do begin
      tick();
      n++;
      k = n % P;
      e = ((k % (D + 1)) != 0 && (k / (D + 1)) == 1) ? 8'h3C : 8'h00;
      checks++;
      if (bus.col_data !== e) begin
        errors++;
        $display("FAIL b2b_mid_col k=%0d: got %h expected %h", k, bus.col_data, e);
      end
    end while (bus.swap_ack !== 1'b1 && n < 3 * P);
    checks++;
    if (n !== P) begin
      errors++;
      $display("FAIL b2b_second_ack_delay: got %0d expected %0d", n, P);
    end
    frame_check("b2b_revert", 3, 8'hA5);
  endtask

  task automatic test_scan_drop();
    int n = 0;
    while (!(m_drive() && m_row() == 5) && n < 2 * P) begin
      tick();
      n++;
    end
    bus.scan_en = 1'b0;
    tick();
    checks++;
    if ({bus.dec_en2, bus.dec_en_b0, bus.dec_en_b1, bus.col_data, bus.row_sel} !== {3'b011, 8'h00, 3'd0}) begin
      errors++;
      $display("FAIL drop_blank: got %h expected %h",
               {bus.dec_en2, bus.dec_en_b0, bus.dec_en_b1, bus.col_data, bus.row_sel}, {3'b011, 8'h00, 3'd0});
    end
    tick(); tick(); tick();
    bus.scan_en = 1'b1;
    tick();
    checks++;
    if ({bus.frame_start, bus.dec_en2, bus.row_sel} !== {1'b1, 1'b0, 3'd0}) begin
      errors++;
      $display("FAIL reenable_blank0: got %b expected 10000", {bus.frame_start, bus.dec_en2, bus.row_sel});
    end
    tick();
    checks++;
    if ({bus.frame_start, bus.dec_en2, bus.row_sel} !== {1'b0, 1'b1, 3'd0}) begin
      errors++;
      $display("FAIL reenable_drive0: got %b expected 01000", {bus.frame_start, bus.dec_en2, bus.row_sel});
    end
  endtask

  task automatic test_random();
    for (int c = 0; c < 800; c++) begin
      bus.scan_en  = ($urandom_range(0, 99) != 0);
      bus.wr_en    = 1'($urandom_range(0, 1));
      bus.wr_row   = 3'($urandom_range(0, 7));
      bus.wr_data  = 8'($urandom);
      bus.swap_req = ($urandom_range(0, 29) == 0);
      tick();
      checks++;
      if (obs_vec() !== exp_vec()) begin
        errors++;
        $display("FAIL random_vec cyc %0d: got %h expected %h", c, obs_vec(), exp_vec());
      end
    end
    bus.wr_en = 1'b0; bus.swap_req = 1'b0; bus.scan_en = 1'b1;
  endtask

  task automatic test_reset_mid();
    int n = 0, acks = 0;
    while (!(m_drive() && m_row() == 0) && n < 2 * P) begin
      tick();
      n++;
    end
    bus.swap_req = 1'b1;
    tick();
    bus.swap_req = 1'b0;
    n = 0;
    while (!(m_active && m_row() == 6) && n < 2 * P) begin
      tick();
      n++;
    end
    reset = 1'b1;
    tick();
    checks++;
    if (obs_vec() !== RESET_VEC) begin
      errors++;
      $display("FAIL midreset_values: got %h expected %h", obs_vec(), RESET_VEC);
    end
    reset = 1'b0;
    for (int c = 0; c < 2 * P + 3; c++) begin
      tick();
      if (bus.swap_ack === 1'b1) acks++;
      checks++;
      if (bus.col_data !== 8'h00) begin
        errors++;
        $display("FAIL midreset_col: got %h expected 00", bus.col_data);
      end
    end
    checks++;
    if (acks !== 0) begin
      errors++;
      $display("FAIL midreset_no_ack: got %0d expected 0", acks);
    end
    bus.swap_req = 1'b1;
    tick();
    bus.swap_req = 1'b0;
    wait_ack("midreset_swap", 2 * P, n);
    frame_check("midreset_backbank", 0, 8'h00);
  endtask

  initial begin
    reset = 1'b1;
    bus.scan_en = 1'b0;
    bus.wr_en = 1'b0;
    bus.wr_row = 3'd0;
    bus.wr_data = 8'h00;
    bus.swap_req = 1'b0;
    @(negedge clk);
    test_reset();
    test_scan();
    test_swap();
    test_drop_write();
    test_back_to_back();
    test_scan_drop();
    test_random();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
